// File: rtl/modmul_stream_ctl_pkg.sv
// Shared definitions for the Montgomery multiplier stream controller:
// modulus construction, stream tag type and the multiplier latency model.
package modmul_stream_ctl_pkg;

  localparam int STREAM_TAG_W = 4;
  typedef logic [STREAM_TAG_W-1:0] stream_tag_t;

  typedef struct packed {
    logic [7:0] logq;
    logic [7:0] logqh;
    logic [3:0] mul_stages;
    logic [3:0] red_stages;
  } modmul_params_t;

  localparam modmul_params_t MODMUL_DEFAULT = '{
    logq:       8'd32,
    logqh:      8'd15,
    mul_stages: 4'd2,
    red_stages: 4'd2
  };

  // Input register + multiply pipeline + reduction pipeline + output register.
  function automatic int modmul_latency(input modmul_params_t p);
    return 2 + int'(p.mul_stages) + int'(p.red_stages);
  endfunction

  // q = qH * 2^w + 1, i.e. {qH, (w-1) zeros, 1}; callers truncate to their width.
  function automatic logic [63:0] q_from_qh(input logic [63:0] qh, input int w);
    return (qh << w) | 64'd1;
  endfunction

endpackage

// File: rtl/modmul_stream_ctl_fifo.sv
// First-word-fall-through FIFO: head entry is visible on dout whenever
// empty is low; storage resets to zero so dout reads 0 out of reset.
module sync_fifo_fwft #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign count   = count_reg;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/modmul_stream_ctl.sv
// Issue/collect controller around a fixed-latency Montgomery multiplier:
// credit-limited issue, valid/tag tracking, final correction, FWFT result buffer.
module modmul_stream_ctl
  import modmul_stream_ctl_pkg::*;
#(
  parameter int LOGQ       = 32,
  parameter int LOGQH      = 15,
  parameter int LAT        = modmul_latency(MODMUL_DEFAULT),
  parameter int CORRECT_IN = 0,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LOGQH-1:0]  qH,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LOGQ-1:0]   in_a,
  input  logic [LOGQ-1:0]   in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [LOGQ-1:0]   mm_a,
  output logic [LOGQ-1:0]   mm_b,
  input  logic [LOGQ:0]     mm_t,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOGQ-1:0]   out_t,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int W     = LOGQ - LOGQH;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic [OCC_W-1:0]            occ_reg;
  logic [OCC_W-1:0]            occ_next;
  logic                        ready_reg;
  logic                        issue;
  logic                        pop;
  logic                        fifo_empty;
  logic [LAT-1:0]              sr_valid_reg;
  logic [LAT-1:0][TAG_W-1:0]   sr_tag_reg;
  logic [LOGQ-1:0]             r;
  logic [LOGQ+TAG_W-1:0]       fifo_dout;

  assign mm_a  = in_a;
  assign mm_b  = in_b;
  assign issue = in_valid & ready_reg;
  assign pop   = out_valid & out_ready;

  always_comb begin
    occ_next = occ_reg + OCC_W'(issue) - OCC_W'(pop);
  end

  // Ready is registered from the next occupancy, so a pop frees its credit one
  // cycle later and there is no out_ready -> in_ready combinational path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      occ_reg   <= occ_next;
      ready_reg <= (occ_next < OCC_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_valid_reg <= '0;
      sr_tag_reg   <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        sr_valid_reg[i] <= sr_valid_reg[i-1];
        sr_tag_reg[i]   <= sr_tag_reg[i-1];
      end
      sr_valid_reg[0] <= issue;
      sr_tag_reg[0]   <= in_tag;
    end
  end

  generate
    if (CORRECT_IN == 0) begin : g_subtract
      logic [LOGQ:0] q_ext;
      assign q_ext = (LOGQ+1)'(q_from_qh(64'(qH), W));
      // mm_t < 2q, so the difference always fits in LOGQ bits.
      assign r = (mm_t >= q_ext) ? (mm_t[LOGQ-1:0] - q_ext[LOGQ-1:0])
                                 : mm_t[LOGQ-1:0];
    end else begin : g_passthrough
      assign r = mm_t[LOGQ-1:0];
    end
  endgenerate

  sync_fifo_fwft #(
    .DATA_W (LOGQ + TAG_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (sr_valid_reg[LAT-1]),
    .din   ({r, sr_tag_reg[LAT-1]}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (),
    .count ()
  );

  assign out_valid = ~fifo_empty;
  assign out_t     = fifo_dout[LOGQ+TAG_W-1:TAG_W];
  assign out_tag   = fifo_dout[TAG_W-1:0];
  assign in_ready  = ready_reg;
  assign busy      = (occ_reg != '0);

endmodule
